// File: rtl/eth_rx_frame_buf_if.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf_if
//   Bundles the byte-wide MAC write stream and the word-wide read stream of
//   the RX frame buffer into a single interface.
//
//   modport slave  : the frame buffer itself
//   modport master : the environment (MAC on the write side, DMA/consumer
//                    on the read side)
//
//   Write side : wr_valid_i, wr_data_i[7:0], wr_last_i, wr_err_i
//   Read side  : rd_valid_o, rd_ready_i, rd_data_o[DATA_W-1:0],
//                rd_be_o[NB-1:0], rd_last_o
//   Status     : frame_avail_o, fill_words_o[ADDR_W:0], drop_o,
//                drop_cnt_o[15:0]
// ---------------------------------------------------------------------------
interface eth_rx_frame_buf_if #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 512
);
  localparam int NB     = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic              wr_valid_i;
  logic [7:0]        wr_data_i;
  logic              wr_last_i;
  logic              wr_err_i;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [NB-1:0]     rd_be_o;
  logic              rd_last_o;
  logic              frame_avail_o;
  logic [ADDR_W:0]   fill_words_o;
  logic              drop_o;
  logic [15:0]       drop_cnt_o;

  modport slave (
    input  wr_valid_i, wr_data_i, wr_last_i, wr_err_i, rd_ready_i,
    output rd_valid_o, rd_data_o, rd_be_o, rd_last_o,
           frame_avail_o, fill_words_o, drop_o, drop_cnt_o
  );

  modport master (
    output wr_valid_i, wr_data_i, wr_last_i, wr_err_i, rd_ready_i,
    input  rd_valid_o, rd_data_o, rd_be_o, rd_last_o,
           frame_avail_o, fill_words_o, drop_o, drop_cnt_o
  );
endinterface

// File: rtl/eth_rx_frame_buf.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_buf
//   Single-clock RX frame buffer for the Ethernet MAC receive path. Bytes
//   from the MAC are packed little-endian into DATA_W-bit words (byte k in
//   lane k). A frame becomes visible to the read side only when it ends
//   with a good last byte; errored or overflowing frames are rolled back so
//   the consumer never sees partial or bad frames.
//
// Ports
//   clk_i   : clock, all logic on the rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : eth_rx_frame_buf_if.slave (write stream, read stream, status)
//
// Parameters
//   DATA_W      : read word width, multiple of 8, >= 16
//   DEPTH_WORDS : buffer depth in words, power of 2, >= 4
//
// Optional feature
//   RXBUF_DROP_CNT_EN : when defined, drop_cnt_o counts dropped frames
//                       (saturating at 16'hFFFF); otherwise drop_cnt_o = 0.
//
// Pointer scheme
//   wrPtr    : next word to write (in-progress frame)
//   cmtPtr   : end of committed data
//   rdPtr    : next word the consumer will take (drives fill/full)
//   fetchPtr : next word to prefetch into the read pipeline; it runs ahead
//              of rdPtr by at most two words and never passes cmtPtr.
//   All pointers carry one extra wrap bit.
// ---------------------------------------------------------------------------
module eth_rx_frame_buf #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 512
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  eth_rx_frame_buf_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int MEM_W  = DATA_W + NB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wrState_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  wrState_t          wrState;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  cmtPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  fetchPtr;
  logic [LANE_W-1:0] laneCnt;
  logic [DATA_W-1:0] packReg;
  logic [PTR_W-1:0]  frameCnt;
  logic              dropReg;

  logic [MEM_W-1:0]  mem [DEPTH_WORDS];
  logic [MEM_W-1:0]  memQ;
  logic              s1Valid;

  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic [NB-1:0]     rdBe;
  logic              rdLast;

  // ------------------------------------------------------------------
  // Write-side decode
  // ------------------------------------------------------------------
  logic              bufFull;
  logic              acceptByte;
  logic              wordDone;
  logic              badLast;
  logic              overflow;
  logic              memWe;
  logic              commitEvt;
  logic [DATA_W-1:0] wordData;
  logic [NB-1:0]     lastBe;
  logic [MEM_W-1:0]  memWdata;

  assign bufFull    = (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]) &&
                      (wrPtr[ADDR_W] != rdPtr[ADDR_W]);
  assign acceptByte = bus.wr_valid_i && (wrState != DISCARD);
  assign wordDone   = (laneCnt == LANE_W'(NB - 1)) || bus.wr_last_i;
  assign badLast    = acceptByte && bus.wr_last_i && bus.wr_err_i;
  // A word that must be stored while full kills the frame; a bad last
  // byte is a rollback regardless of space, so it is excluded here.
  assign overflow   = acceptByte && wordDone && !badLast && bufFull;
  assign memWe      = acceptByte && wordDone && !badLast && !bufFull;
  assign commitEvt  = memWe && bus.wr_last_i;

  // Merge the incoming byte into its lane. packReg is cleared after each
  // word store, so lanes above the current one are always zero and the
  // unused lanes of a short last word read back as 0.
  for (genvar gi = 0; gi < NB; gi++) begin : gLane
    assign wordData[gi*8 +: 8] = (laneCnt == LANE_W'(gi)) ? bus.wr_data_i
                                                          : packReg[gi*8 +: 8];
    assign lastBe[gi]          = (LANE_W'(gi) <= laneCnt);
  end

  // For a non-last word laneCnt is NB-1, so lastBe is all ones there too.
  assign memWdata = {bus.wr_last_i, lastBe, wordData};

  // ------------------------------------------------------------------
  // Write FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrState <= IDLE;
      wrPtr   <= '0;
      cmtPtr  <= '0;
      laneCnt <= '0;
      packReg <= '0;
      dropReg <= 1'b0;
    end else begin
      dropReg <= 1'b0;
      case (wrState)
        IDLE, RECV: begin
          if (badLast) begin
            wrPtr   <= cmtPtr;
            laneCnt <= '0;
            packReg <= '0;
            dropReg <= 1'b1;
            wrState <= IDLE;
          end else if (overflow) begin
            laneCnt <= '0;
            packReg <= '0;
            if (bus.wr_last_i) begin
              // Overflow on the final byte: nothing left to discard.
              wrPtr   <= cmtPtr;
              dropReg <= 1'b1;
              wrState <= IDLE;
            end else begin
              wrState <= DISCARD;
            end
          end else if (memWe) begin
            wrPtr   <= wrPtr + 1'b1;
            laneCnt <= '0;
            packReg <= '0;
            if (bus.wr_last_i) begin
              cmtPtr  <= wrPtr + 1'b1;
              wrState <= IDLE;
            end else begin
              wrState <= RECV;
            end
          end else if (acceptByte) begin
            packReg <= wordData;
            laneCnt <= laneCnt + 1'b1;
            wrState <= RECV;
          end
        end
        DISCARD: begin
          if (bus.wr_valid_i && bus.wr_last_i) begin
            wrPtr   <= cmtPtr;
            dropReg <= 1'b1;
            wrState <= IDLE;
          end
        end
        default: wrState <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Read pipeline: memory read register (s1) feeding the output register.
  // A new fetch is issued whenever s1 is empty or being drained in the
  // same cycle, which sustains one word per cycle.
  // ------------------------------------------------------------------
  logic fetchAvail;
  logic outFire;
  logic outLoad;
  logic rdIssue;
  logic lastFire;

  assign fetchAvail = (fetchPtr != cmtPtr);
  assign outFire    = rdValid && bus.rd_ready_i;
  assign outLoad    = s1Valid && (!rdValid || outFire);
  assign rdIssue    = fetchAvail && (!s1Valid || outLoad);
  assign lastFire   = outFire && rdLast;

  // Storage array: write port from the packer, registered read port.
  always_ff @(posedge clk_i) begin
    if (memWe) begin
      mem[wrPtr[ADDR_W-1:0]] <= memWdata;
    end
    if (rdIssue) begin
      memQ <= mem[fetchPtr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetchPtr <= '0;
      rdPtr    <= '0;
      s1Valid  <= 1'b0;
      rdValid  <= 1'b0;
      rdData   <= '0;
      rdBe     <= '0;
      rdLast   <= 1'b0;
    end else begin
      if (rdIssue) begin
        fetchPtr <= fetchPtr + 1'b1;
      end
      if (outFire) begin
        rdPtr <= rdPtr + 1'b1;
      end

      if (rdIssue) begin
        s1Valid <= 1'b1;
      end else if (outLoad) begin
        s1Valid <= 1'b0;
      end

      if (outLoad) begin
        rdValid                  <= 1'b1;
        {rdLast, rdBe, rdData}   <= memQ;
      end else if (outFire) begin
        rdValid <= 1'b0;
        rdData  <= '0;
        rdBe    <= '0;
        rdLast  <= 1'b0;
      end
    end
  end

  // Committed-frame counter: a commit and a final-word transfer in the
  // same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frameCnt <= '0;
    end else begin
      case ({commitEvt, lastFire})
        2'b10:   frameCnt <= frameCnt + 1'b1;
        2'b01:   frameCnt <= frameCnt - 1'b1;
        default: frameCnt <= frameCnt;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Dropped-frame counter
  // ------------------------------------------------------------------
`ifdef RXBUF_DROP_CNT_EN
  logic [15:0] dropCnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dropCnt <= '0;
    end else if (dropReg && (dropCnt != 16'hFFFF)) begin
      dropCnt <= dropCnt + 16'd1;
    end
  end

  assign bus.drop_cnt_o = dropCnt;
`else
  assign bus.drop_cnt_o = 16'h0000;
`endif

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.rd_valid_o    = rdValid;
  assign bus.rd_data_o     = rdData;
  assign bus.rd_be_o       = rdBe;
  assign bus.rd_last_o     = rdLast;
  assign bus.frame_avail_o = (frameCnt != '0);
  assign bus.fill_words_o  = wrPtr - rdPtr;
  assign bus.drop_o        = dropReg;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame_buf
//   Directed bench for eth_rx_frame_buf. dutA uses DATA_W=32 and the default
//   depth; dutB uses DEPTH_WORDS=4 for the overflow case. A table of frames
//   with hand-computed read words drives dutA, followed by hand-written
//   sequences for stall, overflow and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame_buf;

  logic clk;
  logic rstN;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  eth_rx_frame_buf_if #(.DATA_W(32), .DEPTH_WORDS(512)) busA ();
  eth_rx_frame_buf_if #(.DATA_W(32), .DEPTH_WORDS(4))   busB ();

  eth_rx_frame_buf #(.DATA_W(32), .DEPTH_WORDS(512)) dutA (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (busA)
  );

  eth_rx_frame_buf #(.DATA_W(32), .DEPTH_WORDS(4)) dutB (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (busB)
  );

`ifdef RXBUF_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int          nBytes;
    logic [7:0]  firstByte;
    logic [7:0]  step;
    logic        err;
    int          expWords;
    logic [31:0] expFirst;
    logic [31:0] expLast;
    logic [3:0]  expLastBe;
    int          expDrop;
  } frameVec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } wordVec_t;

  localparam int NVEC = 8;
  frameVec_t vecs [NVEC];
  wordVec_t  stallWords [4];

  int checks = 0;
  int errors = 0;
  int dropSeenA = 0;
  int dropSeenB = 0;

  always @(negedge clk) begin
    if (busA.drop_o) dropSeenA++;
    if (busB.drop_o) dropSeenB++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveByte(input bit useB, input logic valid, input logic [7:0] d,
                           input logic last, input logic err);
    if (useB) begin
      busB.wr_valid_i = valid; busB.wr_data_i = d;
      busB.wr_last_i  = last;  busB.wr_err_i  = err;
    end else begin
      busA.wr_valid_i = valid; busA.wr_data_i = d;
      busA.wr_last_i  = last;  busA.wr_err_i  = err;
    end
  endtask

  task automatic setReady(input bit useB, input logic r);
    if (useB) busB.rd_ready_i = r;
    else      busA.rd_ready_i = r;
  endtask

  // Drives a frame byte-per-cycle; returns on the negedge after the last
  // byte has been sampled.
  task automatic sendFrame(input bit useB, input int nBytes, input logic [7:0] first,
                           input logic [7:0] step, input logic err);
    logic [7:0] b;
    logic       isLast;
    b = first;
    for (int i = 0; i < nBytes; i++) begin
      isLast = (i == nBytes - 1);
      driveByte(useB, 1'b1, b, isLast, isLast ? err : 1'b0);
      @(negedge clk);
      b = b + step;
    end
    driveByte(useB, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sampleRd(input bit useB, output logic v, output logic [31:0] d,
                          output logic [3:0] be, output logic l);
    if (useB) begin
      v = busB.rd_valid_o; d = busB.rd_data_o; be = busB.rd_be_o; l = busB.rd_last_o;
    end else begin
      v = busA.rd_valid_o; d = busA.rd_data_o; be = busA.rd_be_o; l = busA.rd_last_o;
    end
  endtask

  // Reads one frame with rd_ready held high; returns on the negedge after
  // the last word transferred.
  task automatic readFrame(input bit useB, output int nW,
                           output logic [31:0] fD, output logic [3:0] fBe, output logic fL,
                           output logic [31:0] lD, output logic [3:0] lBe, output logic got);
    logic        v;
    logic        l;
    logic [31:0] d;
    logic [3:0]  be;
    int          budget;
    nW = 0; got = 1'b0; fD = '0; fBe = '0; fL = 1'b0; lD = '0; lBe = '0;
    budget = 100;
    setReady(useB, 1'b1);
    while (!got && budget > 0) begin
      sampleRd(useB, v, d, be, l);
      if (v) begin
        if (nW == 0) begin fD = d; fBe = be; fL = l; end
        lD = d; lBe = be; nW++;
        if (l) got = 1'b1;
      end
      @(negedge clk);
      budget--;
    end
    setReady(useB, 1'b0);
  endtask

  // Working variables for the main sequence
  int          d0;
  int          nW;
  int          nXfer;
  int          lastX;
  int          budget;
  logic [31:0] fD;
  logic [31:0] lD;
  logic [3:0]  fBe;
  logic [3:0]  lBe;
  logic        fL;
  logic        got;
  logic        v;
  logic        l;
  logic [31:0] d;
  logic [3:0]  be;
  logic        rdy;
  logic        stalledPrev;
  logic        availPending;
  logic [31:0] heldD;
  logic [3:0]  heldBe;
  logic        heldL;

  initial begin
    //         nBytes first  step   err   words first         last          lastBe   drop
    vecs[0] = '{6,  8'h01, 8'h01, 1'b0, 2, 32'h04030201, 32'h00000605, 4'b0011, 0};
    vecs[1] = '{64, 8'h00, 8'h01, 1'b1, 0, 32'h00000000, 32'h00000000, 4'b0000, 1};
    vecs[2] = '{4,  8'hAA, 8'h11, 1'b0, 1, 32'hDDCCBBAA, 32'hDDCCBBAA, 4'b1111, 0};
    vecs[3] = '{1,  8'h5A, 8'h01, 1'b0, 1, 32'h0000005A, 32'h0000005A, 4'b0001, 0};
    vecs[4] = '{5,  8'h10, 8'h01, 1'b0, 2, 32'h13121110, 32'h00000014, 4'b0001, 0};
    vecs[5] = '{7,  8'h20, 8'h01, 1'b0, 2, 32'h23222120, 32'h00262524, 4'b0111, 0};
    vecs[6] = '{8,  8'h30, 8'h01, 1'b0, 2, 32'h33323130, 32'h37363534, 4'b1111, 0};
    vecs[7] = '{3,  8'h40, 8'h01, 1'b1, 0, 32'h00000000, 32'h00000000, 4'b0000, 1};

    stallWords[0] = '{32'h04030201, 4'b1111, 1'b0};
    stallWords[1] = '{32'h00000605, 4'b0011, 1'b1};
    stallWords[2] = '{32'h33323130, 4'b1111, 1'b0};
    stallWords[3] = '{32'h37363534, 4'b1111, 1'b1};

    rstN = 1'b0;
    driveByte(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    driveByte(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    setReady(1'b0, 1'b0);
    setReady(1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rd_valid", busA.rd_valid_o, 1'b0);
    chk("rst_rd_data", busA.rd_data_o, 32'h0);
    chk("rst_rd_be", busA.rd_be_o, 4'h0);
    chk("rst_rd_last", busA.rd_last_o, 1'b0);
    chk("rst_avail", busA.frame_avail_o, 1'b0);
    chk("rst_fill", busA.fill_words_o, 0);
    chk("rst_drop", busA.drop_o, 1'b0);
    chk("rst_drop_cnt", busA.drop_cnt_o, 0);
    chk("rst_b_valid", busB.rd_valid_o, 1'b0);
    chk("rst_b_fill", busB.fill_words_o, 0);
    $display("reset: outputs checked");
    rstN = 1'b1;
    @(negedge clk);

    // Table of frames on dutA
    for (int vi = 0; vi < NVEC; vi++) begin
      d0 = dropSeenA;
      sendFrame(1'b0, vecs[vi].nBytes, vecs[vi].firstByte, vecs[vi].step, vecs[vi].err);
      @(negedge clk);
      @(negedge clk);
      if (vecs[vi].expWords > 0) begin
        chk("latency_valid", busA.rd_valid_o, 1'b1);
        chk("avail_before", busA.frame_avail_o, 1'b1);
        readFrame(1'b0, nW, fD, fBe, fL, lD, lBe, got);
        chk("got_last", got, 1'b1);
        chk("word_count", nW, vecs[vi].expWords);
        chk("first_data", fD, vecs[vi].expFirst);
        chk("first_be", fBe, (vecs[vi].expWords == 1) ? vecs[vi].expLastBe : 4'b1111);
        chk("first_last", fL, (vecs[vi].expWords == 1) ? 1'b1 : 1'b0);
        chk("last_data", lD, vecs[vi].expLast);
        chk("last_be", lBe, vecs[vi].expLastBe);
        chk("avail_after", busA.frame_avail_o, 1'b0);
        chk("fill_after", busA.fill_words_o, 0);
      end else begin
        chk("dropped_no_valid", busA.rd_valid_o, 1'b0);
        chk("dropped_fill", busA.fill_words_o, 0);
        chk("dropped_avail", busA.frame_avail_o, 1'b0);
      end
      chk("drop_pulses", dropSeenA - d0, vecs[vi].expDrop);
      $display("vec %0d: bytes=%0d err=%0b words=%0d first=%08h last=%08h be=%04b",
               vi, vecs[vi].nBytes, vecs[vi].err, nW, fD, lD, lBe);
      nW = 0; fD = '0; lD = '0; lBe = '0;
    end

    chk("drop_cnt_2", busA.drop_cnt_o, CNT_EN ? 2 : 0);
    sendFrame(1'b0, 2, 8'h70, 8'h01, 1'b1);
    repeat (2) @(negedge clk);
    chk("drop_cnt_3", busA.drop_cnt_o, CNT_EN ? 3 : 0);
    $display("drop counter: %0d after three errored frames", busA.drop_cnt_o);

    // Two queued frames drained with rd_ready toggling every cycle
    sendFrame(1'b0, 6, 8'h01, 8'h01, 1'b0);
    sendFrame(1'b0, 8, 8'h30, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    chk("stall_fill", busA.fill_words_o, 4);
    chk("stall_avail", busA.frame_avail_o, 1'b1);
    chk("stall_valid", busA.rd_valid_o, 1'b1);
    rdy = 1'b0; setReady(1'b0, rdy);
    nXfer = 0; lastX = 0; stalledPrev = 1'b0; availPending = 1'b0; budget = 100;
    heldD = '0; heldBe = '0; heldL = 1'b0;
    while (nXfer < 4 && budget > 0) begin
      sampleRd(1'b0, v, d, be, l);
      if (stalledPrev) begin
        chk("stall_hold_valid", v, 1'b1);
        chk("stall_hold_data", d, heldD);
        chk("stall_hold_be", be, heldBe);
        chk("stall_hold_last", l, heldL);
      end
      if (v && rdy) begin
        chk("stall_word_data", d, stallWords[nXfer].data);
        chk("stall_word_be", be, stallWords[nXfer].be);
        chk("stall_word_last", l, stallWords[nXfer].last);
        $display("stall xfer %0d: data=%08h be=%04b last=%0b", nXfer, d, be, l);
        nXfer++;
        if (l) begin lastX++; availPending = 1'b1; end
        stalledPrev = 1'b0;
      end else if (v) begin
        stalledPrev = 1'b1; heldD = d; heldBe = be; heldL = l;
      end else begin
        stalledPrev = 1'b0;
      end
      @(negedge clk);
      budget--;
      rdy = !rdy; setReady(1'b0, rdy);
      if (availPending) begin
        chk("stall_avail_step", busA.frame_avail_o, (lastX == 1) ? 1'b1 : 1'b0);
        availPending = 1'b0;
      end
    end
    setReady(1'b0, 1'b0);
    chk("stall_xfers", nXfer, 4);
    chk("stall_fill_end", busA.fill_words_o, 0);

    // Overflow on the 4-word instance with no reads
    sendFrame(1'b1, 8, 8'h50, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_fill_first", busB.fill_words_o, 2);
    chk("ovf_avail_first", busB.frame_avail_o, 1'b1);
    d0 = dropSeenB;
    sendFrame(1'b1, 12, 8'h60, 8'h01, 1'b0);
    chk("ovf_drop_on_last", busB.drop_o, 1'b1);
    repeat (2) @(negedge clk);
    chk("ovf_drop_pulses", dropSeenB - d0, 1);
    chk("ovf_fill_back", busB.fill_words_o, 2);
    chk("ovf_avail", busB.frame_avail_o, 1'b1);
    readFrame(1'b1, nW, fD, fBe, fL, lD, lBe, got);
    chk("ovf_got_last", got, 1'b1);
    chk("ovf_words", nW, 2);
    chk("ovf_first", fD, 32'h53525150);
    chk("ovf_first_be", fBe, 4'b1111);
    chk("ovf_last", lD, 32'h57565554);
    chk("ovf_last_be", lBe, 4'b1111);
    chk("ovf_fill_end", busB.fill_words_o, 0);
    chk("ovf_avail_end", busB.frame_avail_o, 1'b0);
    chk("ovf_drop_cnt", busB.drop_cnt_o, CNT_EN ? 1 : 0);
    $display("overflow: words=%0d first=%08h last=%08h", nW, fD, lD);

    // Reset in the middle of a frame with a committed frame pending
    sendFrame(1'b0, 4, 8'hC0, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_pre_valid", busA.rd_valid_o, 1'b1);
    driveByte(1'b0, 1'b1, 8'hE0, 1'b0, 1'b0); @(negedge clk);
    driveByte(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0); @(negedge clk);
    driveByte(1'b0, 1'b1, 8'hE2, 1'b0, 1'b0); @(negedge clk);
    driveByte(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rstN = 1'b0;
    #1;
    chk("mid_rst_valid", busA.rd_valid_o, 1'b0);
    chk("mid_rst_data", busA.rd_data_o, 32'h0);
    chk("mid_rst_be", busA.rd_be_o, 4'h0);
    chk("mid_rst_last", busA.rd_last_o, 1'b0);
    chk("mid_rst_avail", busA.frame_avail_o, 1'b0);
    chk("mid_rst_fill", busA.fill_words_o, 0);
    chk("mid_rst_drop_cnt", busA.drop_cnt_o, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("mid_post_drop", busA.drop_o, 1'b0);
    sendFrame(1'b0, 5, 8'h10, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid", busA.rd_valid_o, 1'b1);
    readFrame(1'b0, nW, fD, fBe, fL, lD, lBe, got);
    chk("mid_got_last", got, 1'b1);
    chk("mid_words", nW, 2);
    chk("mid_first", fD, 32'h13121110);
    chk("mid_last", lD, 32'h00000014);
    chk("mid_last_be", lBe, 4'b0001);
    chk("mid_fill_end", busA.fill_words_o, 0);
    $display("mid-frame reset: words=%0d first=%08h last=%08h", nW, fD, lD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
